// File: rtl/axi_bram_slave.sv
// AXI4 slave front-end for a single-port BRAM with 1-cycle read latency.
// One burst is in flight at a time; simultaneous AW/AR requests are
// arbitrated round-robin, starting write-first after reset.
// Handshake rule: a transfer on any channel happens on the rising clk edge
// where both valid and ready are high; ready never waits on anything but state
// and the opposing request.
module axi_bram_slave #(
  parameter int BRAM_SIZE  = 16,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  localparam int STRB_W    = DATA_WIDTH / 8,
  localparam int OFF_W     = $clog2(STRB_W),
  localparam int ADDR_W    = BRAM_SIZE + OFF_W
) (
  input  logic                  clk,
  input  logic                  rst,
  // write address channel
  input  logic [ID_WIDTH-1:0]   aw_id,
  input  logic [ADDR_W-1:0]     aw_addr,
  input  logic [7:0]            aw_len,
  input  logic [2:0]            aw_size,
  input  logic [1:0]            aw_burst,
  input  logic                  aw_valid,
  output logic                  aw_ready,
  // write data channel
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [STRB_W-1:0]     w_strb,
  input  logic                  w_last,
  input  logic                  w_valid,
  output logic                  w_ready,
  // write response channel
  output logic [ID_WIDTH-1:0]   b_id,
  output logic [1:0]            b_resp,
  output logic                  b_valid,
  input  logic                  b_ready,
  // read address channel
  input  logic [ID_WIDTH-1:0]   ar_id,
  input  logic [ADDR_W-1:0]     ar_addr,
  input  logic [7:0]            ar_len,
  input  logic [2:0]            ar_size,
  input  logic [1:0]            ar_burst,
  input  logic                  ar_valid,
  output logic                  ar_ready,
  // read data channel
  output logic [ID_WIDTH-1:0]   r_id,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [1:0]            r_resp,
  output logic                  r_last,
  output logic                  r_valid,
  input  logic                  r_ready,
  // BRAM port
  output logic                  ram_clk,
  output logic                  ram_en,
  output logic [STRB_W:0]       ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wrdata,
  input  logic [DATA_WIDTH-1:0] ram_rddata,
  // FSM state for observation
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_DATA  = 3'd1,
    B_RESP  = 3'd2,
    R_ISSUE = 3'd3,
    R_DATA  = 3'd4
  } state_t;

  state_t              state;
  logic                prio_w;   // 1: write side wins a tie
  logic [ID_WIDTH-1:0] id;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   inc;
  logic [7:0]          cnt;      // beats remaining after the current one

  logic grant_w;
  logic grant_r;

  // Burst type and w_last do not influence anything: all bursts run as INCR
  // and the latched length alone ends a write burst.
  logic unused_inputs;
  assign unused_inputs = ^{aw_burst, ar_burst, w_last};

  assign grant_w = aw_valid && (!ar_valid || prio_w);
  assign grant_r = ar_valid && (!aw_valid || !prio_w);

  assign aw_ready = !rst && (state == IDLE) && grant_w;
  assign ar_ready = !rst && (state == IDLE) && grant_r;

  assign w_ready  = (state == W_DATA);
  assign b_valid  = (state == B_RESP);
  assign b_id     = id;
  assign b_resp   = 2'b00;

  assign r_valid  = (state == R_DATA);
  assign r_data   = ram_rddata;
  assign r_id     = id;
  assign r_resp   = 2'b00;
  assign r_last   = (state == R_DATA) && (cnt == 8'd0);

  assign ram_clk    = clk;
  assign ram_addr   = addr;
  assign ram_wrdata = w_data;
  assign state_dbg  = state;

  // BRAM strobes: a write beat drives enable and byte lanes, a read issue
  // drives enable alone.
  always_comb begin
    ram_en = 1'b0;
    ram_we = '0;
    if (state == W_DATA) begin
      ram_en = w_valid;
      ram_we = {1'b0, w_strb & {STRB_W{w_valid}}};
    end else if (state == R_ISSUE) begin
      ram_en = 1'b1;
    end
  end

  // Transaction FSM: arbitration, burst address/count tracking, responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      prio_w <= 1'b1;
      id     <= '0;
      addr   <= '0;
      inc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_w) begin
            id    <= aw_id;
            addr  <= aw_addr;
            cnt   <= aw_len;
            inc   <= ADDR_W'(1) << aw_size;
            state <= W_DATA;
            if (ar_valid) prio_w <= 1'b0;
          end else if (grant_r) begin
            id    <= ar_id;
            addr  <= ar_addr;
            cnt   <= ar_len;
            inc   <= ADDR_W'(1) << ar_size;
            state <= R_ISSUE;
            if (aw_valid) prio_w <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_valid) begin
            addr <= addr + inc;
            cnt  <= cnt - 8'd1;
            if (cnt == 8'd0) state <= B_RESP;
          end
        end
        B_RESP: begin
          if (b_ready) state <= IDLE;
        end
        R_ISSUE: begin
          state <= R_DATA;
        end
        R_DATA: begin
          if (r_ready) begin
            if (cnt == 8'd0) begin
              state <= IDLE;
            end else begin
              addr  <= addr + inc;
              cnt   <= cnt - 8'd1;
              state <= R_ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_bram_slave.sv
// Bench for axi_bram_slave: table of write-then-readback bursts plus
// hand-written arbitration and mid-burst reset sequences. A BRAM model is
// attached to the RAM port; a separate shadow memory supplies expected data.
module tb_axi_bram_slave;

  localparam int AW = 19;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]    aw_id, ar_id, b_id, r_id;
  logic [AW-1:0] aw_addr, ar_addr, ram_addr;
  logic [7:0]    aw_len, ar_len, w_strb;
  logic [2:0]    aw_size, ar_size, state_dbg;
  logic [1:0]    aw_burst, ar_burst, b_resp, r_resp;
  logic          aw_valid, aw_ready, ar_valid, ar_ready;
  logic [63:0]   w_data, r_data, ram_wrdata, ram_rddata;
  logic          w_last, w_valid, w_ready;
  logic          b_valid, b_ready, r_last, r_valid, r_ready;
  logic          ram_clk, ram_en;
  logic [8:0]    ram_we;

  axi_bram_slave dut (
    .clk(clk), .rst(rst),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size),
    .aw_burst(aw_burst), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid),
    .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
    .ar_burst(ar_burst), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
    .r_valid(r_valid), .r_ready(r_ready),
    .ram_clk(ram_clk), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wrdata(ram_wrdata), .ram_rddata(ram_rddata),
    .state_dbg(state_dbg)
  );

  // BRAM model: byte-lane writes, registered read
  bit [63:0] mem [0:65535];
  always @(posedge ram_clk) begin
    if (ram_en) begin
      for (int b = 0; b < 8; b++)
        if (ram_we[b]) mem[ram_addr[18:3]][8*b +: 8] <= ram_wrdata[8*b +: 8];
      ram_rddata <= mem[ram_addr[18:3]];
    end
  end

  // scoreboard
  bit [63:0]   shadow [0:65535];
  logic [63:0] exp_q[$];
  int tests = 0;
  int failed = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic shadow_write(input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] s);
    for (int b = 0; b < 8; b++)
      if (s[b]) shadow[a[18:3]][8*b +: 8] = d[8*b +: 8];
  endtask

  function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] a, input int beat, input logic [2:0] s);
    return a + AW'(beat << s);
  endfunction

  // driver tasks: all start and end 1 time unit after a rising edge
  task automatic do_aw(input logic [AW-1:0] a, input logic [7:0] l, input logic [2:0] s, input logic [3:0] i);
    aw_addr = a; aw_len = l; aw_size = s; aw_id = i; aw_burst = 2'b01; aw_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (aw_ready) break;
    end
    check("aw_ready", 64'(aw_ready), 64'd1);
    @(posedge clk); #1;
    aw_valid = 1'b0;
  endtask

  task automatic do_ar(input logic [AW-1:0] a, input logic [7:0] l, input logic [2:0] s, input logic [3:0] i);
    ar_addr = a; ar_len = l; ar_size = s; ar_id = i; ar_burst = 2'b01; ar_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ar_ready) break;
    end
    check("ar_ready", 64'(ar_ready), 64'd1);
    @(posedge clk); #1;
    ar_valid = 1'b0;
  endtask

  task automatic w_beats(input logic [AW-1:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [7:0] strb, input logic [63:0] d0, input logic [3:0] i,
                         input logic gap, input logic [1:0] exp_resp);
    logic [AW-1:0] ea;
    for (int beat = 0; beat <= int'(l); beat++) begin
      if (gap && beat == 1) begin
        w_valid = 1'b0;
        @(negedge clk);
        check("gap_ram_en", 64'(ram_en), 64'd0);
        check("gap_ram_we", 64'(ram_we), 64'd0);
        @(posedge clk); #1;
      end
      ea = beat_addr(a, beat, s);
      w_valid = 1'b1; w_data = d0 + 64'(beat); w_strb = strb; w_last = (beat == int'(l));
      @(negedge clk);
      check("w_ready", 64'(w_ready), 64'd1);
      check("w_ram_en", 64'(ram_en), 64'd1);
      check("w_ram_addr", 64'(ram_addr), 64'(ea));
      check("w_ram_we", 64'(ram_we), 64'({1'b0, strb}));
      @(posedge clk); #1;
      shadow_write(ea, d0 + 64'(beat), strb);
    end
    w_valid = 1'b0; w_last = 1'b0;
    @(negedge clk);
    check("b_valid", 64'(b_valid), 64'd1);
    check("b_resp", 64'(b_resp), 64'(exp_resp));
    check("b_id", 64'(b_id), 64'(i));
    check("b_w_ready", 64'(w_ready), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic r_beats(input logic [AW-1:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [3:0] i, input int stall);
    logic [AW-1:0] ea;
    logic [63:0]   e;
    for (int beat = 0; beat <= int'(l); beat++) begin
      ea = beat_addr(a, beat, s);
      exp_q.push_back(shadow[ea[18:3]]);
      @(negedge clk);
      check("ri_ram_en", 64'(ram_en), 64'd1);
      check("ri_ram_we", 64'(ram_we), 64'd0);
      check("ri_ram_addr", 64'(ram_addr), 64'(ea));
      check("ri_r_valid", 64'(r_valid), 64'd0);
      @(posedge clk); #1;
      if (beat == 0 && stall > 0) begin
        r_ready = 1'b0;
        for (int k = 0; k < stall; k++) begin
          @(negedge clk);
          check("stall_r_valid", 64'(r_valid), 64'd1);
          check("stall_r_data", r_data, exp_q[0]);
          check("stall_ram_en", 64'(ram_en), 64'd0);
          @(posedge clk); #1;
        end
        r_ready = 1'b1;
      end
      @(negedge clk);
      check("r_valid", 64'(r_valid), 64'd1);
      if (r_valid && r_ready) begin
        if (exp_q.size() == 0) begin
          check("exp_q_empty", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("r_data", r_data, e);
        end
      end
      check("r_last", 64'(r_last), 64'(beat == int'(l)));
      check("r_id", 64'(r_id), 64'(i));
      check("r_resp", 64'(r_resp), 64'd0);
      check("r_ram_en", 64'(ram_en), 64'd0);
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [7:0]    strb;
    logic [63:0]   data0;
    logic [3:0]    id;
    logic          gap;
    int            stall;
    logic [1:0]    exp_resp;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    vecs[0] = '{19'h00010, 8'd0, 3'd3, 8'hFF, 64'h1122334455667788, 4'd1, 1'b0, 0, 2'b00};
    vecs[1] = '{19'h00100, 8'd3, 3'd3, 8'hFF, 64'd1,                 4'd2, 1'b0, 0, 2'b00};
    vecs[2] = '{19'h00020, 8'd0, 3'd3, 8'hFF, 64'd0,                 4'd3, 1'b0, 0, 2'b00};
    vecs[3] = '{19'h00020, 8'd0, 3'd3, 8'h0F, 64'hFFFFFFFFFFFFFFFF,  4'd4, 1'b0, 0, 2'b00};
    vecs[4] = '{19'h7FFF8, 8'd2, 3'd3, 8'hFF, 64'hDEAD0000BEEF0000,  4'd5, 1'b0, 0, 2'b00};
    vecs[5] = '{19'h00400, 8'd3, 3'd2, 8'hF0, 64'h0123456789ABCDEF,  4'd6, 1'b0, 0, 2'b00};
    vecs[6] = '{19'h01238, 8'd7, 3'd3, 8'hA5, {$urandom, $urandom},  4'd7, 1'b1, 0, 2'b00};
    vecs[7] = '{19'h00500, 8'd1, 3'd3, 8'hFF, {$urandom, $urandom},  4'd8, 1'b0, 5, 2'b00};

    aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0; aw_valid = 1'b0;
    ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0; ar_valid = 1'b0;
    w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0;
    b_ready = 1'b1; r_ready = 1'b1;

    // reset state, with requests pending to show readies stay low in reset
    repeat (2) @(posedge clk);
    #1;
    aw_valid = 1'b1; ar_valid = 1'b1;
    @(negedge clk);
    check("rst_state", 64'(state_dbg), 64'd0);
    check("rst_aw_ready", 64'(aw_ready), 64'd0);
    check("rst_ar_ready", 64'(ar_ready), 64'd0);
    check("rst_w_ready", 64'(w_ready), 64'd0);
    check("rst_b_valid", 64'(b_valid), 64'd0);
    check("rst_r_valid", 64'(r_valid), 64'd0);
    check("rst_ram_en", 64'(ram_en), 64'd0);
    check("rst_ram_we", 64'(ram_we), 64'd0);
    aw_valid = 1'b0; ar_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // table: write burst, then read it back
    for (int v = 0; v < 8; v++) begin
      do_aw(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].id);
      w_beats(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].strb, vecs[v].data0,
              vecs[v].id, vecs[v].gap, vecs[v].exp_resp);
      do_ar(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].id ^ 4'h8);
      r_beats(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].id ^ 4'h8, vecs[v].stall);
      @(negedge clk);
      check("idle_after_burst", 64'(state_dbg), 64'd0);
      @(posedge clk); #1;
    end
    check("partial_strb_word", 64'(shadow[4]), 64'h00000000FFFFFFFF);

    // arbitration: both valid after reset -> write, next tie -> read
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    aw_addr = 19'h00200; aw_len = 8'd0; aw_size = 3'd3; aw_id = 4'd5; aw_valid = 1'b1;
    ar_addr = 19'h00200; ar_len = 8'd0; ar_size = 3'd3; ar_id = 4'd6; ar_valid = 1'b1;
    @(negedge clk);
    check("arb1_aw_ready", 64'(aw_ready), 64'd1);
    check("arb1_ar_ready", 64'(ar_ready), 64'd0);
    @(posedge clk); #1;
    aw_addr = 19'h00208; aw_id = 4'd7;
    w_beats(19'h00200, 8'd0, 3'd3, 8'hFF, 64'hCAFEF00D12345678, 4'd5, 1'b0, 2'b00);
    @(negedge clk);
    check("arb2_ar_ready", 64'(ar_ready), 64'd1);
    check("arb2_aw_ready", 64'(aw_ready), 64'd0);
    @(posedge clk); #1;
    ar_valid = 1'b0;
    r_beats(19'h00200, 8'd0, 3'd3, 4'd6, 0);
    @(negedge clk);
    check("arb3_aw_ready", 64'(aw_ready), 64'd1);
    @(posedge clk); #1;
    aw_valid = 1'b0;
    w_beats(19'h00208, 8'd0, 3'd3, 8'h3C, 64'h5555AAAA5555AAAA, 4'd7, 1'b0, 2'b00);

    // reset in the middle of a 4-beat write burst
    do_aw(19'h00300, 8'd3, 3'd3, 4'd9);
    w_beats(19'h00300, 8'd3, 3'd3, 8'hFF, 64'h00000000000000A0, 4'd9, 1'b0, 2'b00);
    do_aw(19'h00300, 8'd3, 3'd3, 4'd10);
    for (int beat = 0; beat < 2; beat++) begin
      w_valid = 1'b1; w_data = 64'h00000000000000B0 + 64'(beat); w_strb = 8'hFF;
      @(posedge clk); #1;
      shadow_write(beat_addr(19'h00300, beat, 3'd3), 64'h00000000000000B0 + 64'(beat), 8'hFF);
    end
    w_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_state", 64'(state_dbg), 64'd0);
    check("mid_rst_b_valid", 64'(b_valid), 64'd0);
    check("mid_rst_w_ready", 64'(w_ready), 64'd0);
    @(posedge clk); #1;
    do_ar(19'h00300, 8'd3, 3'd3, 4'd11);
    r_beats(19'h00300, 8'd3, 3'd3, 4'd11, 0);
    check("mid_rst_beat2_kept", 64'(shadow[19'h00310 >> 3]), 64'h00000000000000A2);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
